// File: rtl/inst_loader_mem_pkg.sv
// Shared definitions for the instruction memory boot loader: FSM states,
// acknowledge bytes and the stream framing constant.
package inst_loader_mem_pkg;

    typedef enum logic [2:0] {
        StSize,
        StData,
        StAck,
        StErr,
        StRun
    } loader_state_e;

    localparam logic [7:0]  ACK_BYTE       = 8'hAA;
    localparam logic [7:0]  ERR_BYTE       = 8'hEE;
    localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/inst_loader_mem_bram.sv
// Single-clock word RAM: one write port, one read-first read port whose
// data register is loaded from the sampled address on every posedge.
module inst_bram #(
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned DEPTH  = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    logic [31:0]       mem [DEPTH];
    logic [31:0]       rdata_q;
    logic [ADDR_W-1:0] rd_sel;

    // Reset only steers the read toward word 0; contents are never cleared.
    assign rd_sel = rstn ? raddr : '0;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_q <= mem[rd_sel];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/inst_loader_mem.sv
// Instruction memory with UART boot loader: fills the RAM from a
// length-prefixed big-endian byte stream, then releases the core.
module inst_loader_mem #(
    parameter int unsigned ADDR_W   = 17,
    parameter int unsigned DEPTH    = 1 << ADDR_W,
    parameter logic [7:0]  ACK_BYTE = inst_loader_mem_pkg::ACK_BYTE,
    parameter logic [7:0]  ERR_BYTE = inst_loader_mem_pkg::ERR_BYTE
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [31:0]       inst_data,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              core_rstn,
    output logic [ADDR_W:0]   load_count
);

    import inst_loader_mem_pkg::*;

    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    loader_state_e     state_q;
    logic [1:0]        byte_cnt_q;
    logic [23:0]       shift_q;
    logic [ADDR_W:0]   n_q;
    logic [ADDR_W:0]   load_count_q;
    logic [ADDR_W:0]   count_next;
    logic [31:0]       word_next;
    logic              we_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [31:0]       wdata_q;
    logic              tx_valid_q;
    logic [7:0]        tx_data_q;
    logic              tx_sent_q;
    logic              core_rstn_q;

    assign word_next  = {shift_q, rx_data};
    assign count_next = load_count_q + 1'b1;

    always_ff @(posedge clk) begin
        we_q <= 1'b0;
        if (!rstn) begin
            state_q      <= StSize;
            byte_cnt_q   <= '0;
            shift_q      <= '0;
            n_q          <= '0;
            load_count_q <= '0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            tx_valid_q   <= 1'b0;
            tx_data_q    <= 8'h00;
            tx_sent_q    <= 1'b0;
            core_rstn_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StSize: begin
                    if (rx_valid) begin
                        byte_cnt_q <= byte_cnt_q + 1'b1;
                        shift_q    <= word_next[23:0];
                        if (byte_cnt_q == LAST_BYTE) begin
                            if (word_next > DEPTH) begin
                                state_q <= StErr;
                            end else if (word_next == '0) begin
                                state_q <= StAck;
                            end else begin
                                n_q     <= word_next[ADDR_W:0];
                                state_q <= StData;
                            end
                        end
                    end
                end
                StData: begin
                    if (rx_valid) begin
                        byte_cnt_q <= byte_cnt_q + 1'b1;
                        shift_q    <= word_next[23:0];
                        if (byte_cnt_q == LAST_BYTE) begin
                            we_q         <= 1'b1;
                            waddr_q      <= load_count_q[ADDR_W-1:0];
                            wdata_q      <= word_next;
                            load_count_q <= count_next;
                            if (count_next == n_q) begin
                                state_q <= StAck;
                            end
                        end
                    end
                end
                StAck: begin
                    if (!tx_valid_q) begin
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= ACK_BYTE;
                    end else if (tx_ready) begin
                        tx_valid_q  <= 1'b0;
                        core_rstn_q <= 1'b1;
                        state_q     <= StRun;
                    end
                end
                StErr: begin
                    // One error byte per reset; afterwards the loader stays mute.
                    if (!tx_valid_q && !tx_sent_q) begin
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= ERR_BYTE;
                    end else if (tx_valid_q && tx_ready) begin
                        tx_valid_q <= 1'b0;
                        tx_sent_q  <= 1'b1;
                    end
                end
                StRun: begin
                end
                default: state_q <= StSize;
            endcase
        end
    end

    inst_bram #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_bram (
        .clk   (clk),
        .rstn  (rstn),
        .we    (we_q),
        .waddr (waddr_q),
        .wdata (wdata_q),
        .raddr (inst_addr),
        .rdata (inst_data)
    );

    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign core_rstn  = core_rstn_q;
    assign load_count = load_count_q;

endmodule

// File: tb/tb_inst_loader_mem.sv
// Directed bench for inst_loader_mem: load, empty, oversize, backpressure,
// read-during-write and mid-load reset sequences.
module tb_inst_loader_mem;

    localparam int unsigned ADDR_W = 17;

    logic              clk;
    logic              rstn;
    logic [ADDR_W-1:0] inst_addr;
    logic [31:0]       inst_data;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              core_rstn;
    logic [ADDR_W:0]   load_count;

    int tests;
    int fails;

    inst_loader_mem #(
        .ADDR_W (ADDR_W)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .inst_addr  (inst_addr),
        .inst_data  (inst_data),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .core_rstn  (core_rstn),
        .load_count (load_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rstn     = 1'b0;
        rx_valid = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic read_check(input string tag, input logic [ADDR_W-1:0] a,
                              input logic [31:0] exp);
        inst_addr = a;
        tick();
        check(tag, 64'(inst_data), 64'(exp));
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        inst_addr = '0;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        tx_ready  = 1'b1;

        // Reset state
        do_reset();
        check("rst_tx_valid", 64'(tx_valid), 64'd0);
        check("rst_tx_data", 64'(tx_data), 64'h00);
        check("rst_core_rstn", 64'(core_rstn), 64'd0);
        check("rst_load_count", 64'(load_count), 64'd0);

        // Basic two-word load
        send_word(32'h0000_0002);
        send_word(32'hDEAD_BEEF);
        check("load_mid_count", 64'(load_count), 64'd1);
        check("load_mid_core", 64'(core_rstn), 64'd0);
        send_word(32'h0123_4567);
        check("load_tx_not_yet", 64'(tx_valid), 64'd0);
        tick();
        check("load_tx_valid", 64'(tx_valid), 64'd1);
        check("load_tx_data", 64'(tx_data), 64'hAA);
        check("load_core_low", 64'(core_rstn), 64'd0);
        tick();
        check("load_core_high", 64'(core_rstn), 64'd1);
        check("load_tx_drop", 64'(tx_valid), 64'd0);
        check("load_count", 64'(load_count), 64'd2);
        read_check("load_rd0", 17'd0, 32'hDEAD_BEEF);
        read_check("load_rd1", 17'd1, 32'h0123_4567);
        // RUN ignores rx bytes
        send_word(32'h5555_5555);
        check("run_count", 64'(load_count), 64'd2);
        read_check("run_rd0", 17'd0, 32'hDEAD_BEEF);
        check("run_core", 64'(core_rstn), 64'd1);

        // Empty program
        do_reset();
        send_word(32'h0000_0000);
        tick();
        check("empty_tx_valid", 64'(tx_valid), 64'd1);
        check("empty_tx_data", 64'(tx_data), 64'hAA);
        tick();
        check("empty_core", 64'(core_rstn), 64'd1);
        check("empty_count", 64'(load_count), 64'd0);

        // Six words with backpressure in ACK
        do_reset();
        send_word(32'h0000_0006);
        for (int i = 0; i < 6; i++) send_word(32'hA000_0000 + 32'(i));
        tx_ready = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            check("bp_tx_valid", 64'(tx_valid), 64'd1);
            check("bp_tx_data", 64'(tx_data), 64'hAA);
            check("bp_core", 64'(core_rstn), 64'd0);
            tick();
        end
        tx_ready = 1'b1;
        tick();
        check("bp_core_rise", 64'(core_rstn), 64'd1);
        check("bp_count", 64'(load_count), 64'd6);
        read_check("bp_rd5", 17'd5, 32'hA000_0005);

        // Read during write of word 5
        do_reset();
        send_word(32'h0000_0006);
        for (int i = 0; i < 5; i++) send_word(32'hB000_0000 + 32'(i));
        send_word(32'hB000_0005);
        inst_addr = 17'd5;
        tick();
        check("rdw_old", 64'(inst_data), 64'hA000_0005);
        tick();
        check("rdw_new", 64'(inst_data), 64'hB000_0005);
        tick();
        check("rdw_core", 64'(core_rstn), 64'd1);

        // Oversize count DEPTH+1
        do_reset();
        send_word(32'h0002_0001);
        tick();
        check("ovr_tx_valid", 64'(tx_valid), 64'd1);
        check("ovr_tx_data", 64'(tx_data), 64'hEE);
        tick();
        check("ovr_tx_drop", 64'(tx_valid), 64'd0);
        send_word(32'hFFFF_FFFF);
        send_word(32'hFFFF_FFFF);
        tick();
        check("ovr_tx_quiet", 64'(tx_valid), 64'd0);
        check("ovr_core", 64'(core_rstn), 64'd0);
        check("ovr_count", 64'(load_count), 64'd0);
        read_check("ovr_rd0", 17'd0, 32'hB000_0000);

        // Mid-load reset after 1.5 words
        do_reset();
        send_word(32'h0000_0002);
        send_word(32'h1234_5678);
        send_byte(8'h9A);
        send_byte(8'hBC);
        check("mlr_mid_count", 64'(load_count), 64'd1);
        do_reset();
        check("mlr_rst_count", 64'(load_count), 64'd0);
        check("mlr_rst_tx", 64'(tx_valid), 64'd0);
        read_check("mlr_keep0", 17'd0, 32'h1234_5678);
        send_word(32'h0000_0001);
        send_word(32'hCAFE_F00D);
        tick();
        check("mlr_tx_valid", 64'(tx_valid), 64'd1);
        check("mlr_tx_data", 64'(tx_data), 64'hAA);
        tick();
        check("mlr_core", 64'(core_rstn), 64'd1);
        check("mlr_count", 64'(load_count), 64'd1);
        read_check("mlr_rd0", 17'd0, 32'hCAFE_F00D);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
